jtkcpu_brseq: RTL and testbench
===============================

# jtkcpu_brseq

Branch sequencer for the JTKCPU execution unit. It consumes the taken/not-taken decision from the branch-condition evaluator together with the branch opcode. It then fetches the 8- or 16-bit relative offset from the instruction stream, pushes the return address for BSR/LBSR, and writes the new PC. It sits between the condition evaluator and the PC register and bus/stack arbiter.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle request; op, branch and pc_in valid this cycle
- op  in  8  branch opcode
- branch  in  1  condition result, sampled with start
- pc_in  in  16  address of first offset byte (PC after opcode)
- rd_req  out  1  offset-byte read request
- rd_addr  out  16  offset-byte address
- rd_ack  in  1  read complete; rd_din valid this cycle
- rd_din  in  8  offset byte
- push_req  out  1  stack push request
- push_data  out  8  byte to push
- push_ack  in  1  push accepted this cycle
- pc_out  out  16  new PC
- pc_we  out  1  one-cycle PC write strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse, coincident with pc_we

## Operation
- Opcode classes:
  - Short: 60–67, 70–77, AA (BSR); length 1.
  - Long: 68–6F, 78–7F, AB (LBSR); length 2.
  - Subroutine: AA, AB; always treated as taken, branch input ignored.
  - Any other op: start ignored, no activity.
- ret = pc_in + length, mod 2^16.
- Offset: short is sign-extended rd_din; long is {first byte, second byte} (big-endian).
- Target: taken gives ret + offset mod 2^16; not taken gives ret.
- States:
  - IDLE: on start with a valid op, go to FETCH_HI (long) or FETCH_LO (short).
  - FETCH_HI: rd_addr = pc_in; on rd_ack latch the high byte, go to FETCH_LO.
  - FETCH_LO: rd_addr = ret−1; on rd_ack latch the low byte; go to PUSH_LO if subroutine, else UPDATE.
  - PUSH_LO: push_data = ret[7:0]; on push_ack go to PUSH_HI.
  - PUSH_HI: push_data = ret[15:8]; on push_ack go to UPDATE.
  - UPDATE: pc_we = done = 1, pc_out = result; next state IDLE.
- start while busy is ignored; no queuing.
- op, branch and pc_in are latched at start; later changes have no effect.

## Timing
- Reset values: rd_req, push_req, pc_we, done and busy are 0; rd_addr, push_data and pc_out are 0; state is IDLE.
- Registered request outputs:
  - rd_req is high in FETCH_* states; push_req is high in PUSH_* states.
  - Each request stays high until acked. The ack is sampled on the same edge that leaves the state.
  - rd_addr and push_data are stable while their request is high.
- Zero-wait latency, with start at cycle N:
  - Short: rd_req at N+1, pc_we at N+2.
  - Long: rd_req at N+1 and N+2, pc_we at N+3.
  - BSR: pc_we at N+4. LBSR: pc_we at N+5.
- Each wait cycle on an ack adds one cycle.
- The earliest next start is accepted in the cycle after done.
- Reset mid-operation: abort immediately. No pc_we, and no further requests after rst_n falls. A push already acked is not undone.

## Configuration
- JTKCPU_BRFAST_EN defined:
  - A not-taken, non-subroutine branch skips the fetch states: IDLE goes to UPDATE, and pc_we = 1 at N+1 with pc_out = ret.
  - No rd_req is issued.
- Undefined: offset bytes are always fetched, preserving original bus-cycle behaviour.

## Structure
- jtkcpu_pkg holds:
  - the state enum;
  - opcode constants OP_BRA, OP_LBRA, OP_BSR, OP_LBSR;
  - the short and long range bases 8'h60, 8'h68, 8'h70, 8'h78.
- Sub-module jtkcpu_brdec (combinational) takes op and outputs valid, long and sub.
- The condition evaluator remains external and drives branch.

## Test plan
- BRA (60), pc_in=1000, rd_din=FE, zero-wait → rd_addr=1000 at N+1; pc_out=0FFF with pc_we at N+2.
- LBEQ (7B), branch=1, pc_in=2000, bytes 12,34 → rd_addr 2000 then 2001; pc_out=3236 at N+3.
- LBSR (AB), pc_in=FFF0, bytes 00,20 → pushes F2 then FF; pc_out=0012 (wrap); done at N+5.
- BNE (63), branch=0, pc_in=4000:
  - With JTKCPU_BRFAST_EN: no rd_req, pc_out=4001 at N+1.
  - Without it: one read of 4000, pc_out=4001 at N+2.
- Timing and robustness:
  - rd_ack delayed 3 cycles on a short branch → pc_we at N+5.
  - A start pulse during busy → ignored.
  - rst_n low during PUSH_HI → no pc_we; all outputs 0.
- op=86 with start → busy, rd_req, push_req and pc_we stay 0.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtkcpu_pkg                                                   |
// | Description : Shared types and constants for the JTKCPU branch sequencer.  |
// |               Holds the sequencer state encoding, the branch opcode        |
// |               constants and the opcode range bases.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package jtkcpu_pkg;

  // Sequencer states; IDLE must stay at zero so reset lands there.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_HI = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_PUSH_HI  = 3'd4,
    ST_UPDATE   = 3'd5
  } brseq_state_e;

  // Representative branch opcodes.
  localparam logic [7:0] OP_BRA  = 8'h60;
  localparam logic [7:0] OP_LBRA = 8'h68;
  localparam logic [7:0] OP_BSR  = 8'hAA;
  localparam logic [7:0] OP_LBSR = 8'hAB;

  // Each range covers eight consecutive opcodes starting at its base.
  localparam logic [7:0] SHORT_BASE_A = 8'h60;
  localparam logic [7:0] LONG_BASE_A  = 8'h68;
  localparam logic [7:0] SHORT_BASE_B = 8'h70;
  localparam logic [7:0] LONG_BASE_B  = 8'h78;

  // Sign-extend an 8-bit relative offset to PC width.
  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtkcpu_brdec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtkcpu_brdec                                                 |
// | Description : Combinational branch-opcode classifier. Flags whether an     |
// |               opcode is a branch at all, whether it carries a 16-bit       |
// |               offset, and whether it is a subroutine call.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtkcpu_brdec
  import jtkcpu_pkg::*;
(
  input  logic [7:0] op,
  output logic       valid,
  output logic       is_long,
  output logic       sub
);

  logic is_short;

  // Range match on the upper five opcode bits plus the two call opcodes.
  always_comb begin
    is_short = (op[7:3] == SHORT_BASE_A[7:3]) ||
               (op[7:3] == SHORT_BASE_B[7:3]) ||
               (op == OP_BSR);
    is_long  = (op[7:3] == LONG_BASE_A[7:3]) ||
               (op[7:3] == LONG_BASE_B[7:3]) ||
               (op == OP_LBSR);
    sub      = (op == OP_BSR) || (op == OP_LBSR);
    valid    = is_short || is_long;
  end

endmodule
`default_nettype wire

// File: rtl/jtkcpu_brseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtkcpu_brseq                                                 |
// | Description : Branch sequencer. Fetches the relative offset, pushes the    |
// |               return address for BSR/LBSR and writes the new PC.           |
// |               Optional: define JTKCPU_BRFAST_EN to skip the offset fetch   |
// |               for not-taken, non-subroutine branches.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtkcpu_brseq
  import jtkcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic        branch,
  input  logic [15:0] pc_in,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_din,
  output logic        push_req,
  output logic [7:0]  push_data,
  input  logic        push_ack,
  output logic [15:0] pc_out,
  output logic        pc_we,
  output logic        busy,
  output logic        done
);

  brseq_state_e state_q, state_d;

  // Transaction context captured at start.
  logic        long_q,   long_d;
  logic        sub_q,    sub_d;
  logic        taken_q,  taken_d;
  logic [15:0] ret_q,    ret_d;
  logic [7:0]  hi_q,     hi_d;
  logic [15:0] target_q, target_d;

  // Registered bus-facing outputs.
  logic        rd_req_q,    rd_req_d;
  logic [15:0] rd_addr_q,   rd_addr_d;
  logic        push_req_q,  push_req_d;
  logic [7:0]  push_data_q, push_data_d;
  logic        pc_we_q,     pc_we_d;
  logic [15:0] pc_out_q,    pc_out_d;

  logic        dec_valid;
  logic        dec_long;
  logic        dec_sub;
  logic [15:0] start_ret;
  logic [15:0] offset;

  jtkcpu_brdec u_dec (
    .op      (op),
    .valid   (dec_valid),
    .is_long (dec_long),
    .sub     (dec_sub)
  );

  // Next-state and datapath logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    sub_d       = sub_q;
    taken_d     = taken_q;
    ret_d       = ret_q;
    hi_d        = hi_q;
    target_d    = target_q;
    rd_addr_d   = rd_addr_q;
    push_data_d = push_data_q;

    start_ret = pc_in + (dec_long ? 16'd2 : 16'd1);
    // A long offset is big-endian: the high byte arrives first.
    offset    = long_q ? {hi_q, rd_din} : sext8(rd_din);

    case (state_q)
      ST_IDLE: begin
        if (start && dec_valid) begin
          long_d    = dec_long;
          sub_d     = dec_sub;
          taken_d   = dec_sub | branch;
          ret_d     = start_ret;
          // First offset byte always sits at pc_in, whatever the length.
          rd_addr_d = pc_in;
`ifdef JTKCPU_BRFAST_EN
          if (!dec_sub && !branch) begin
            target_d = start_ret;
            state_d  = ST_UPDATE;
          end else begin
            state_d  = dec_long ? ST_FETCH_HI : ST_FETCH_LO;
          end
`else
          state_d = dec_long ? ST_FETCH_HI : ST_FETCH_LO;
`endif
        end
      end
      ST_FETCH_HI: begin
        if (rd_ack) begin
          hi_d      = rd_din;
          rd_addr_d = ret_q - 16'd1;
          state_d   = ST_FETCH_LO;
        end
      end
      ST_FETCH_LO: begin
        if (rd_ack) begin
          target_d = taken_q ? (ret_q + offset) : ret_q;
          if (sub_q) begin
            push_data_d = ret_q[7:0];
            state_d     = ST_PUSH_LO;
          end else begin
            state_d     = ST_UPDATE;
          end
        end
      end
      ST_PUSH_LO: begin
        if (push_ack) begin
          push_data_d = ret_q[15:8];
          state_d     = ST_PUSH_HI;
        end
      end
      ST_PUSH_HI: begin
        if (push_ack) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_req_d   = (state_d == ST_FETCH_HI) || (state_d == ST_FETCH_LO);
    push_req_d = (state_d == ST_PUSH_LO)  || (state_d == ST_PUSH_HI);
    pc_we_d    = (state_d == ST_UPDATE);
    pc_out_d   = (state_d == ST_UPDATE) ? target_d : pc_out_q;
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      long_q      <= 1'b0;
      sub_q       <= 1'b0;
      taken_q     <= 1'b0;
      ret_q       <= 16'd0;
      hi_q        <= 8'd0;
      target_q    <= 16'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 16'd0;
      push_req_q  <= 1'b0;
      push_data_q <= 8'd0;
      pc_we_q     <= 1'b0;
      pc_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      sub_q       <= sub_d;
      taken_q     <= taken_d;
      ret_q       <= ret_d;
      hi_q        <= hi_d;
      target_q    <= target_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      push_req_q  <= push_req_d;
      push_data_q <= push_data_d;
      pc_we_q     <= pc_we_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign push_req  = push_req_q;
  assign push_data = push_data_q;
  assign pc_we     = pc_we_q;
  assign done      = pc_we_q;
  assign pc_out    = pc_out_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_brseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtkcpu_brseq                                              |
// | Description : Self-checking bench for jtkcpu_brseq: directed table,        |
// |               multi-cycle corner sequences and randomized transactions     |
// |               against a behavioural model. Honours JTKCPU_BRFAST_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtkcpu_brseq;

`ifdef JTKCPU_BRFAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  op;
  logic        branch;
  logic [15:0] pc_in;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_din;
  logic        push_req;
  logic [7:0]  push_data;
  logic        push_ack;
  logic [15:0] pc_out;
  logic        pc_we;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtkcpu_brseq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .branch    (branch),
    .pc_in     (pc_in),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_din    (rd_din),
    .push_req  (push_req),
    .push_data (push_data),
    .push_ack  (push_ack),
    .pc_out    (pc_out),
    .pc_we     (pc_we),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [7:0]  op;
    logic        br;
    logic [15:0] pc;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          rwait;
    int          pwait;
    bit          busy_start;
    logic [15:0] exp_pc;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the opcode classes and offset rules.
  task automatic model(input logic [7:0] m_op, input logic m_br, input logic [15:0] m_pc,
                       input logic [7:0] m_b0, input logic [7:0] m_b1,
                       output int nrd, output int npush,
                       output logic [15:0] a0, output logic [15:0] a1,
                       output logic [7:0] p0, output logic [7:0] p1,
                       output logic [15:0] res);
    int  o, len, ret, off, tgt;
    bit  is_long, sub, taken;
    o       = int'(m_op);
    is_long = (o >= 'h68 && o <= 'h6F) || (o >= 'h78 && o <= 'h7F) || (o == 'hAB);
    sub     = (o == 'hAA) || (o == 'hAB);
    taken   = sub || m_br;
    len     = is_long ? 2 : 1;
    ret     = (int'(m_pc) + len) % 65536;
    if (is_long) off = int'(m_b0) * 256 + int'(m_b1);
    else         off = (m_b0 < 8'd128) ? int'(m_b0) : int'(m_b0) - 256;
    tgt     = taken ? (((ret + off) % 65536) + 65536) % 65536 : ret;
    nrd     = (FAST && !taken) ? 0 : len;
    npush   = sub ? 2 : 0;
    a0      = m_pc;
    a1      = 16'((int'(m_pc) + 1) % 65536);
    p0      = 8'(ret % 256);
    p1      = 8'(ret / 256);
    res     = 16'(tgt);
  endtask

  // Drives one transaction with given ack delays and checks bus activity, result and latency.
  task automatic run_txn(input vec_t v);
    int nrd, npush, ridx, pidx, rw, pw;
    logic [15:0] a0, a1, res;
    logic [7:0]  p0, p1;
    bit seen;
    model(v.op, v.br, v.pc, v.b0, v.b1, nrd, npush, a0, a1, p0, p1, res);
    ridx = 0; pidx = 0; rw = 0; pw = 0; seen = 0;
    chk("idle_before_start", {60'd0, busy, pc_we, rd_req, push_req}, 64'd0);
    start = 1'b1; op = v.op; branch = v.br; pc_in = v.pc;
    step();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      start = 1'b0; op = 8'($urandom); branch = 1'($urandom); pc_in = 16'($urandom);
      rd_ack = 1'b0; push_ack = 1'b0; rd_din = 8'($urandom);
      if (pc_we) begin
        chk("pc_out", {48'd0, pc_out}, {48'd0, v.exp_pc});
        chk("latency", 64'(cyc), 64'(v.exp_lat));
        chk("done_with_pc_we", {63'd0, done}, 64'd1);
        chk("read_count", 64'(ridx), 64'(nrd));
        chk("push_count", 64'(pidx), 64'(npush));
        seen = 1;
        break;
      end
      chk("busy_during_txn", {63'd0, busy}, 64'd1);
      if (rd_req) begin
        if (ridx >= nrd) chk("rd_unexpected", {63'd0, rd_req}, 64'd0);
        else begin
          chk("rd_addr", {48'd0, rd_addr}, {48'd0, (ridx == 0) ? a0 : a1});
          if (rw == v.rwait) begin
            rd_ack = 1'b1; rd_din = (ridx == 0) ? v.b0 : v.b1; ridx++; rw = 0;
          end else rw++;
        end
      end
      if (push_req) begin
        if (pidx >= npush) chk("push_unexpected", {63'd0, push_req}, 64'd0);
        else begin
          chk("push_data", {56'd0, push_data}, {56'd0, (pidx == 0) ? p0 : p1});
          if (pw == v.pwait) begin
            push_ack = 1'b1; pidx++; pw = 0;
          end else pw++;
        end
      end
      if (v.busy_start && (cyc == 1 || cyc == 2)) begin
        start = 1'b1; op = 8'h60; branch = 1'b1; pc_in = 16'hBEEF;
      end
      step();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL pc_we_timeout: got no pc_we expected pc_we within 60 cycles");
    end
    rd_ack = 1'b0; push_ack = 1'b0; start = 1'b0;
    step();
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    int nrd, npush, lat, cls;
    logic [15:0] a0, a1, res;
    logic [7:0]  p0, p1;

    rst_n = 1'b0; start = 1'b0; op = 8'd0; branch = 1'b0; pc_in = 16'd0;
    rd_ack = 1'b0; rd_din = 8'd0; push_ack = 1'b0;

    tbl[0] = '{8'h60, 1'b1, 16'h1000, 8'hFE, 8'h00, 0, 0, 1'b0, 16'h0FFF, 2};
    tbl[1] = '{8'h7B, 1'b1, 16'h2000, 8'h12, 8'h34, 0, 0, 1'b0, 16'h3236, 3};
    tbl[2] = '{8'hAB, 1'b0, 16'hFFF0, 8'h00, 8'h20, 0, 0, 1'b0, 16'h0012, 5};
    tbl[3] = '{8'h63, 1'b0, 16'h4000, 8'h55, 8'h00, 0, 0, 1'b0, 16'h4001, FAST ? 1 : 2};
    tbl[4] = '{8'h60, 1'b1, 16'h1000, 8'hFE, 8'h00, 3, 0, 1'b0, 16'h0FFF, 5};
    tbl[5] = '{8'hAA, 1'b0, 16'h00FF, 8'h80, 8'h00, 0, 1, 1'b1, 16'h0080, 6};
    tbl[6] = '{8'h6F, 1'b0, 16'h1234, 8'h11, 8'h22, 0, 0, 1'b1, 16'h1236, FAST ? 1 : 3};
    tbl[7] = '{8'h77, 1'b1, 16'h8000, 8'h7F, 8'h00, 1, 0, 1'b1, 16'h8080, 3};

    step(); step();
    chk("reset_outputs", {rd_addr, push_data, pc_out, 3'd0, rd_req, push_req, pc_we, done, busy}, 64'd0);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) run_txn(tbl[i]);

    // Invalid opcode: start must be ignored entirely.
    start = 1'b1; op = 8'h86; branch = 1'b1; pc_in = 16'h1111;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("invalid_op_idle", {60'd0, busy, rd_req, push_req, pc_we}, 64'd0);
      step();
    end

    // Reset asserted while waiting in PUSH_HI: everything clears, no PC write follows.
    start = 1'b1; op = 8'hAB; branch = 1'b0; pc_in = 16'h3000;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rd_ack = 1'b0; push_ack = 1'b0;
      if (rd_req) begin rd_ack = 1'b1; rd_din = 8'h01; end
      if (push_req && push_data == 8'h02) push_ack = 1'b1;
      if (push_req && push_data == 8'h30) break;
      step();
    end
    chk("reached_push_hi", {56'd0, push_data}, 64'h30);
    rd_ack = 1'b0; push_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_abort_outputs", {rd_addr, push_data, pc_out, 3'd0, rd_req, push_req, pc_we, done, busy}, 64'd0);
    push_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_hold_quiet", {61'd0, pc_we, rd_req, push_req}, 64'd0);
    end
    push_ack = 1'b0;
    rst_n = 1'b1;
    step();

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      cls = int'($urandom_range(0, 5));
      case (cls)
        0: rv.op = 8'h60 + 8'($urandom_range(0, 7));
        1: rv.op = 8'h70 + 8'($urandom_range(0, 7));
        2: rv.op = 8'h68 + 8'($urandom_range(0, 7));
        3: rv.op = 8'h78 + 8'($urandom_range(0, 7));
        4: rv.op = 8'hAA;
        default: rv.op = 8'hAB;
      endcase
      rv.br = 1'($urandom); rv.pc = 16'($urandom);
      rv.b0 = 8'($urandom); rv.b1 = 8'($urandom);
      rv.rwait = int'($urandom_range(0, 2)); rv.pwait = int'($urandom_range(0, 2));
      rv.busy_start = 1'($urandom);
      model(rv.op, rv.br, rv.pc, rv.b0, rv.b1, nrd, npush, a0, a1, p0, p1, res);
      lat = 1 + nrd * (1 + rv.rwait) + npush * (1 + rv.pwait);
      rv.exp_pc = res; rv.exp_lat = lat;
      run_txn(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
